fp_regfile_sb: RTL and testbench
================================

FP_REGFILE_SB -- requirements
Module: fp_regfile_sb

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The module SHALL have parameter NREG, default 32, meaning register count (power of two, >=2); AW = $clog2(NREG).
REQ-003 The module SHALL have parameter NRD, default 3, meaning read port count (three for fused multiply-add).
REQ-004 The module SHALL have parameter NWR, default 2, meaning write-back port count.
REQ-005 The module SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1 and is a normal register when 0.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 stall  input  1  write and issue gate; high blocks register writes and busy-bit sets.
REQ-009 flush  input  1  clears all busy bits.
REQ-010 wr_en  input  NWR  per-port write enable.
REQ-011 wr_addr  input  NWR*AW  packed write addresses (port j at bits [j*AW +: AW]).
REQ-012 wr_data  input  NWR*DATA_W  packed write data.
REQ-013 rd_en  input  NRD  per-port read enable.
REQ-014 rd_addr  input  NRD*AW  packed read addresses.
REQ-015 rd_data  output  NRD*DATA_W  packed read data.
REQ-016 rd_busy  output  NRD  addressed register has a pending write.
REQ-017 iss_en  input  1  instruction issue marks a destination pending.
REQ-018 iss_addr  input  AW  destination register of the issuing instruction.
REQ-019 busy_cnt  output  AW+1  number of registers currently marked busy.

Function
REQ-020 Reads SHALL be combinational: rd_data[i] = 0 when !rd_en[i] or (ZERO_REG and rd_addr[i]==0), else the register value.
REQ-021 Read bypass: when a qualifying write (REQ-022) targets rd_addr[i] in the same cycle, rd_data[i] SHALL return that write's wr_data; among several qualifying writes, the highest port index wins.
REQ-022 A write on port j SHALL qualify when wr_en[j] && !stall && !(ZERO_REG && wr_addr[j]==0); it updates the register at the rising edge.
REQ-023 Multiple qualifying writes to the same address in one cycle SHALL store the highest-index port's data; writes to distinct addresses all commit.
REQ-024 Busy bit for register r SHALL be set at the edge when iss_en && !stall && iss_addr==r && !(ZERO_REG && r==0).
REQ-025 Busy bit for register r SHALL clear at the edge when any qualifying write targets r.
REQ-026 Simultaneous set and clear of the same register SHALL leave it set (the newer issue wins).
REQ-027 flush SHALL clear every busy bit at the next edge regardless of stall, overriding sets and clears that cycle; register data is unaffected.
REQ-028 rd_busy[i] SHALL be busy[rd_addr[i]] && rd_en[i] && !(a qualifying write to rd_addr[i] this cycle); it is 0 for hardwired register 0.
REQ-029 busy_cnt SHALL be a registered population count of busy bits, updated in the same edge as the bits, range 0..NREG.
REQ-030 With stall high, register contents and busy bits SHALL hold (except flush), and reads and bypass are evaluated with writes disqualified.

Reset
REQ-031 While rst is high, all registers SHALL be 0, all busy bits 0, busy_cnt 0; rd_data therefore reads 0.
REQ-032 Reset asserted mid-operation SHALL discard pending writes and issues immediately (asynchronously); the first edge after release behaves normally.

Verification
REQ-033 Reset, then wr_en[0]=1, addr 5, data 0x3F800000; next cycle read addr 5 on port 2 -> 0x3F800000, rd_busy=0.
REQ-034 Same cycle, port0 and port1 both write addr 7 (0x11111111 and 0x22222222), port0 reads 7 -> bypass 0x22222222; next cycle reads 0x22222222.
REQ-035 Issue addr 3 -> busy_cnt 1, rd_busy on addr 3 = 1; write addr 3 plus issue addr 3 same cycle -> busy stays 1, data updated.
REQ-036 stall=1 with write addr 9 (0xDEADBEEF) and issue addr 4 -> addr 9 unchanged, busy_cnt unchanged, read addr 9 returns the old value (no bypass).
REQ-037 ZERO_REG=1: write addr 0 with 0xFFFFFFFF and issue addr 0 -> read addr 0 = 0, busy_cnt 0; ZERO_REG=0 build -> read 0xFFFFFFFF.
REQ-038 Three busy registers, flush=1 with stall=1 -> busy_cnt 0 next cycle, register data intact.

Source files
------------

// File: rtl/fp_regfile_sb_if.sv
// Bundle of the register file's write, read, issue and scoreboard signals.
// The pipeline side drives it through the master modport; the register file sits on the slave modport.
interface fp_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 3,
  parameter int NWR    = 2
);
  localparam int AW = $clog2(NREG);

  logic                  stall;
  logic                  flush;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NRD-1:0]        rd_en;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  iss_en;
  logic [AW-1:0]         iss_addr;
  logic [AW:0]           busy_cnt;

  modport master (
    output stall, flush, wr_en, wr_addr, wr_data, rd_en, rd_addr, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  stall, flush, wr_en, wr_addr, wr_data, rd_en, rd_addr, iss_en, iss_addr,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/fp_regfile_sb.sv
// Multi-port floating-point register file with a scoreboard of per-register busy bits.
// It bypasses same-cycle writes to the read ports and keeps a registered count of busy registers.
module fp_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 3,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  fp_regfile_sb_if.slave bus
);
  localparam int AW        = $clog2(NREG);
  localparam int CW        = AW + 1;
  localparam bit HARD_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_nxt;
  logic [NWR-1:0]    wr_ok;

  // A write is live only outside reset and stall, and never to the hardwired zero register
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wr_ok[j] = bus.wr_en[j] && !bus.stall && !rst &&
                 !(HARD_ZERO && bus.wr_addr[j*AW +: AW] == '0);
    end
  end

  // Later ports overwrite earlier ones, so the highest index wins on an address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // The set is applied after the clears so that a new issue beats a retiring write; flush beats both
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) busy_nxt[bus.wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (bus.iss_en && !bus.stall && !(HARD_ZERO && bus.iss_addr == '0))
      busy_nxt[bus.iss_addr] = 1'b1;
    if (bus.flush) busy_nxt = '0;
    cnt_nxt = '0;
    for (int r = 0; r < NREG; r++) cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // A matching live write overrides the stored value and hides the busy bit it is about to clear
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (bus.rd_en[i] && !(HARD_ZERO && bus.rd_addr[i*AW +: AW] == '0)) begin
        bus.rd_data[i*DATA_W +: DATA_W] = regs[bus.rd_addr[i*AW +: AW]];
        bus.rd_busy[i] = busy[bus.rd_addr[i*AW +: AW]];
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW]) begin
            bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data[j*DATA_W +: DATA_W];
            bus.rd_busy[i] = 1'b0;
          end
        end
      end
    end
  end

  assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_fp_regfile_sb.sv
// Directed bench for fp_regfile_sb: a table of single-cycle vectors, followed by hand-written sequences.
// The sequences cover asynchronous reset during operation and a build where register 0 is an ordinary register.
module tb_fp_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fp_regfile_sb_if #(.DATA_W(32), .NREG(32), .NRD(3), .NWR(2)) bus ();
  fp_regfile_sb_if #(.DATA_W(32), .NREG(32), .NRD(3), .NWR(2)) bus2 ();

  fp_regfile_sb #(.DATA_W(32), .NREG(32), .NRD(3), .NWR(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fp_regfile_sb #(.DATA_W(32), .NREG(32), .NRD(3), .NWR(2), .ZERO_REG(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic [1:0]  wr_en;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [2:0]  rd_en;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        iss_en;
    logic [4:0]  ia;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [2:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mkv(
    input logic st, input logic fl, input logic [1:0] we,
    input logic [4:0] a0, input logic [31:0] d0, input logic [4:0] a1, input logic [31:0] d1,
    input logic [2:0] re, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
    input logic ie, input logic [4:0] ia,
    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
    input logic [2:0] eb, input logic [5:0] ec);
    vec_t v;
    v.stall = st; v.flush = fl; v.wr_en = we;
    v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.rd_en = re; v.ra0 = r0; v.ra1 = r1; v.ra2 = r2;
    v.iss_en = ie; v.ia = ia;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.stall    = v.stall;
    bus.flush    = v.flush;
    bus.wr_en    = v.wr_en;
    bus.wr_addr  = {v.wa1, v.wa0};
    bus.wr_data  = {v.wd1, v.wd0};
    bus.rd_en    = v.rd_en;
    bus.rd_addr  = {v.ra2, v.ra1, v.ra0};
    bus.iss_en   = v.iss_en;
    bus.iss_addr = v.ia;
    #1;
  endtask

  task automatic idleBus2();
    bus2.stall = 0; bus2.flush = 0; bus2.wr_en = '0; bus2.wr_addr = '0; bus2.wr_data = '0;
    bus2.rd_en = '0; bus2.rd_addr = '0; bus2.iss_en = 0; bus2.iss_addr = '0;
  endtask

  initial begin
    //                 st fl we   wa0 wd0           wa1 wd1           re     r0  r1  r2  ie ia  e0            e1            e2            eb      ec
    vecs[0]  = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b111, 5,  7,  3,  0, 0,  32'h0,        32'h0,        32'h0,        3'b000, 0);
    vecs[1]  = mkv(0, 0, 2'b01, 5,  32'h3F800000, 0,  32'h0,        3'b100, 0,  0,  5,  0, 0,  32'h0,        32'h0,        32'h3F800000, 3'b000, 0);
    vecs[2]  = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b100, 0,  0,  5,  0, 0,  32'h0,        32'h0,        32'h3F800000, 3'b000, 0);
    vecs[3]  = mkv(0, 0, 2'b11, 7,  32'h11111111, 7,  32'h22222222, 3'b001, 7,  0,  0,  0, 0,  32'h22222222, 32'h0,        32'h0,        3'b000, 0);
    vecs[4]  = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b101, 7,  5,  5,  0, 0,  32'h22222222, 32'h0,        32'h3F800000, 3'b000, 0);
    vecs[5]  = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b001, 3,  0,  0,  1, 3,  32'h0,        32'h0,        32'h0,        3'b000, 0);
    vecs[6]  = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b001, 3,  0,  0,  0, 0,  32'h0,        32'h0,        32'h0,        3'b001, 1);
    vecs[7]  = mkv(0, 0, 2'b01, 3,  32'hAAAA5555, 0,  32'h0,        3'b011, 3,  3,  0,  1, 3,  32'hAAAA5555, 32'hAAAA5555, 32'h0,        3'b000, 1);
    vecs[8]  = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b111, 3,  3,  3,  0, 0,  32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 3'b111, 1);
    vecs[9]  = mkv(0, 0, 2'b10, 0,  32'h0,        9,  32'h12345678, 3'b010, 0,  9,  0,  0, 0,  32'h0,        32'h12345678, 32'h0,        3'b000, 1);
    vecs[10] = mkv(1, 0, 2'b01, 9,  32'hDEADBEEF, 0,  32'h0,        3'b111, 9,  4,  3,  1, 4,  32'h12345678, 32'h0,        32'hAAAA5555, 3'b100, 1);
    vecs[11] = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b111, 9,  4,  3,  0, 0,  32'h12345678, 32'h0,        32'hAAAA5555, 3'b100, 1);
    vecs[12] = mkv(0, 0, 2'b01, 0,  32'hFFFFFFFF, 0,  32'h0,        3'b001, 0,  0,  0,  1, 0,  32'h0,        32'h0,        32'h0,        3'b000, 1);
    vecs[13] = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b001, 0,  0,  0,  0, 0,  32'h0,        32'h0,        32'h0,        3'b000, 1);
    vecs[14] = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b000, 0,  0,  0,  1, 10, 32'h0,        32'h0,        32'h0,        3'b000, 1);
    vecs[15] = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b000, 0,  0,  0,  1, 11, 32'h0,        32'h0,        32'h0,        3'b000, 2);
    vecs[16] = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b111, 10, 11, 3,  0, 0,  32'h0,        32'h0,        32'hAAAA5555, 3'b111, 3);
    vecs[17] = mkv(1, 1, 2'b01, 10, 32'h0BADF00D, 0,  32'h0,        3'b111, 10, 11, 3,  1, 12, 32'h0,        32'h0,        32'hAAAA5555, 3'b111, 3);
    vecs[18] = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b111, 12, 11, 3,  0, 0,  32'h0,        32'h0,        32'hAAAA5555, 3'b000, 0);
    vecs[19] = mkv(0, 1, 2'b00, 0,  32'h0,        0,  32'h0,        3'b000, 0,  0,  0,  1, 6,  32'h0,        32'h0,        32'h0,        3'b000, 0);
    vecs[20] = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b001, 6,  0,  0,  0, 0,  32'h0,        32'h0,        32'h0,        3'b000, 0);
    vecs[21] = mkv(0, 0, 2'b11, 13, 32'h13131313, 14, 32'h14141414, 3'b110, 0,  13, 14, 1, 8,  32'h0,        32'h13131313, 32'h14141414, 3'b000, 0);
    vecs[22] = mkv(0, 0, 2'b10, 0,  32'h0,        8,  32'h00000088, 3'b111, 8,  13, 14, 0, 0,  32'h00000088, 32'h13131313, 32'h14141414, 3'b000, 1);
    vecs[23] = mkv(0, 0, 2'b00, 0,  32'h0,        0,  32'h0,        3'b001, 8,  0,  0,  0, 0,  32'h00000088, 32'h0,        32'h0,        3'b000, 0);

    idleBus2();
    bus.stall = 0; bus.flush = 0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = 0; bus.iss_addr = '0;
    bus.rd_en = 3'b111; bus.rd_addr = {5'd5, 5'd5, 5'd5};
    #1;
    checkOutput("reset.rd_data", 96'(bus.rd_data), 96'h0);
    checkOutput("reset.busy_cnt", 96'(bus.busy_cnt), 96'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("v%0d.rd_data", k), 96'(bus.rd_data), {vecs[k].e2, vecs[k].e1, vecs[k].e0});
      checkOutput($sformatf("v%0d.rd_busy", k), 96'(bus.rd_busy), 96'(vecs[k].eb));
      checkOutput($sformatf("v%0d.busy_cnt", k), 96'(bus.busy_cnt), 96'(vecs[k].ec));
    end

    // Reset in the middle of a write/issue cycle throws both away at once
    applyStimulus(mkv(0, 0, 2'b01, 5, 32'h77777777, 0, 32'h0, 3'b001, 5, 0, 0, 1, 5,
                      32'h0, 32'h0, 32'h0, 3'b000, 0));
    rst = 1'b1;
    #1;
    checkOutput("midrst.rd_data", 96'(bus.rd_data), 96'h0);
    checkOutput("midrst.rd_busy", 96'(bus.rd_busy), 96'h0);
    checkOutput("midrst.busy_cnt", 96'(bus.busy_cnt), 96'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("postrst.bypass", 96'(bus.rd_data), 96'h77777777);
    @(negedge clk);
    bus.wr_en = '0;
    bus.iss_en = 0;
    #1;
    checkOutput("postrst.rd_data", 96'(bus.rd_data), 96'h77777777);
    checkOutput("postrst.rd_busy", 96'(bus.rd_busy), 96'h1);
    checkOutput("postrst.busy_cnt", 96'(bus.busy_cnt), 96'h1);

    // With ZERO_REG=0, register 0 behaves like any other register
    @(negedge clk);
    bus2.wr_en = 2'b01; bus2.wr_addr = '0; bus2.wr_data = {32'h0, 32'hFFFFFFFF};
    bus2.iss_en = 1; bus2.iss_addr = '0;
    bus2.rd_en = 3'b001; bus2.rd_addr = '0;
    #1;
    checkOutput("zr0.bypass", 96'(bus2.rd_data), 96'hFFFFFFFF);
    @(negedge clk);
    bus2.wr_en = '0; bus2.iss_en = 0;
    #1;
    checkOutput("zr0.rd_data", 96'(bus2.rd_data), 96'hFFFFFFFF);
    checkOutput("zr0.rd_busy", 96'(bus2.rd_busy), 96'h1);
    checkOutput("zr0.busy_cnt", 96'(bus2.busy_cnt), 96'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
